// File: rtl/madd_seq_if.sv
// Interface bundling the execute-stage side of the MADD-family sequencer.
// The pipeline (master) drives the operands and control, and the sequencer
// (slave) returns the stall request and the HI/LO write-back.
interface madd_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic [1:0]           op_i;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic [2*WIDTH-1:0]   hilo_i;
    logic [5:0]           stall_i;
    logic                 flush_i;
    logic                 stallreq_o;
    logic                 busy_o;
    logic [WIDTH-1:0]     hi_o;
    logic [WIDTH-1:0]     lo_o;
    logic                 whilo_o;
    logic                 done_o;

    modport master (
        output start_i, op_i, a_i, b_i, hilo_i, stall_i, flush_i,
        input  stallreq_o, busy_o, hi_o, lo_o, whilo_o, done_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, hilo_i, stall_i, flush_i,
        output stallreq_o, busy_o, hi_o, lo_o, whilo_o, done_o
    );
endinterface

// File: rtl/madd_seq.sv
// Multi-cycle sequencer for MADD, MADDU, MSUB and MSUBU.
// The product is registered in the first cycle, and the HI/LO accumulate is
// registered in the second. The result is then offered to EX/MEM until
// execute is released.
module madd_seq #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    madd_seq_if.slave  bus
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [PW-1:0]   a_ext;
    logic [PW-1:0]   b_ext;
    logic [PW-1:0]   product_next;
    logic [PW-1:0]   product;
    logic [PW-1:0]   hilo_q;
    logic [PW-1:0]   result;
    logic            sub_q;
    logic            launch;

    logic            stallreq;
    logic            busy;
    logic            whilo;
    logic            done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Only the execute-hold bit matters here. The other stall bits belong to
    // stages this block never waits on.
    logic            unused_stall_bits;
    assign unused_stall_bits = ^{bus.stall_i[5:3], bus.stall_i[1:0]};

    // Operand extension: zero-extend for the unsigned forms, sign-extend
    // otherwise. The low 2*WIDTH bits of the wide product are then correct
    // for both forms.
    always_comb begin
        if (bus.op_i[1]) begin
            a_ext = {{WIDTH{1'b0}}, bus.a_i};
            b_ext = {{WIDTH{1'b0}}, bus.b_i};
        end else begin
            a_ext = {{WIDTH{bus.a_i[WIDTH-1]}}, bus.a_i};
            b_ext = {{WIDTH{bus.b_i[WIDTH-1]}}, bus.b_i};
        end
        product_next = a_ext * b_ext;
    end

    assign launch = (state == IDLE) && bus.start_i && !bus.flush_i;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: latch the product and operands at launch, then form the
    // accumulate in ACC.
    // NOTE: these are plain data registers, but they are still reset, so the
    // result bus reads zero after reset and never carries stale X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            product <= '0;
            hilo_q  <= '0;
            sub_q   <= 1'b0;
            result  <= '0;
        end else begin
            if (launch) begin
                product <= product_next;
                hilo_q  <= bus.hilo_i;
                sub_q   <= bus.op_i[0];
            end
            if (state == ACC && !bus.flush_i) begin
                result <= sub_q ? (hilo_q - product) : (hilo_q + product);
            end
        end
    end

    // Next-state and output decode.
    // NOTE: every output gets a default before the case statement, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        stallreq   = 1'b0;
        busy       = 1'b0;
        whilo      = 1'b0;
        done       = 1'b0;
        hi         = '0;
        lo         = '0;
        unique case (state)
            IDLE: begin
                // The IDLE stall request follows start_i, but it is held low
                // while reset is asserted so that every output is quiet in reset.
                stallreq = bus.start_i & rst;
                if (launch) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                stallreq   = 1'b1;
                busy       = 1'b1;
                state_next = bus.flush_i ? IDLE : DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                // A squashed instruction must never write HI/LO.
                whilo    = !bus.flush_i;
                {hi, lo} = result;
                // start_i is still high for this same instruction, so it is
                // deliberately ignored here.
                if (bus.flush_i || !bus.stall_i[2]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.stallreq_o = stallreq;
    assign bus.busy_o     = busy;
    assign bus.whilo_o    = whilo;
    assign bus.done_o     = done;
    assign bus.hi_o       = hi;
    assign bus.lo_o       = lo;

endmodule
